// File: rtl/qsim_pkg.sv
// qsim_pkg: shared definitions for the state-vector transfer path.
//   - default widths for amplitude data, local state address and PE index
//   - global off-chip address width ({PE index, local address})
//   - transfer sequencer state encoding
package qsim_pkg;

  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_STATE_ADDR_WIDTH = 16;
  localparam int DEF_PE_NUM_WIDTH     = 2;
  localparam int GLOBAL_ADDR_WIDTH    = DEF_PE_NUM_WIDTH + DEF_STATE_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_UNLOAD = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/xfer_fifo.sv
// xfer_fifo: synchronous show-ahead FIFO buffering unload data.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears storage too,
//                   so rd_data reads 0 after reset)
//   push, wr_data   write side; a push while full is accepted only with a pop
//   pop, rd_data    read side; rd_data is the head entry, pop ignored if empty
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module xfer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign rd_data = mem[rptr];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/state_xfer_ctrl.sv
// state_xfer_ctrl: moves amplitudes between a host stream and the per-PE
// state memories through the broadcast off-chip port (port A of every LSU).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_start/i_dir/i_base_addr/i_count  command (dir 0 = load, 1 = unload)
//   o_busy, o_done              status; o_done is a one-cycle pulse
//   i_s_valid/o_s_ready/i_s_data       load stream in
//   o_m_valid/i_m_ready/o_m_data       unload stream out
//   o_state_ram_off_chip_*      off-chip port: en, we, global addr, write data
//   i_pe_rd_data                port-A read data of all PEs, PE k at k*SDW
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for i_start
// ST_LOAD   | accepting stream beats, one port write per accepted beat
// ST_UNLOAD | issuing port reads while FIFO credit remains
// ST_FLUSH  | all reads issued; draining in-flight reads and the FIFO
// ST_DONE   | one-cycle completion pulse
module state_xfer_ctrl
  import qsim_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH = DEF_STATE_ADDR_WIDTH,
  parameter int PE_NUM_WIDTH     = DEF_PE_NUM_WIDTH,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_start,
  input  logic                                       i_dir,
  input  logic [PE_NUM_WIDTH+STATE_ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [PE_NUM_WIDTH+STATE_ADDR_WIDTH:0]     i_count,
  output logic                                       o_busy,
  output logic                                       o_done,
  input  logic                                       i_s_valid,
  output logic                                       o_s_ready,
  input  logic [STATE_DATA_WIDTH-1:0]                i_s_data,
  output logic                                       o_m_valid,
  input  logic                                       i_m_ready,
  output logic [STATE_DATA_WIDTH-1:0]                o_m_data,
  output logic                                       o_state_ram_off_chip_en,
  output logic                                       o_state_ram_off_chip_we,
  output logic [PE_NUM_WIDTH+STATE_ADDR_WIDTH-1:0]   o_state_ram_off_chip_addr,
  output logic [STATE_DATA_WIDTH-1:0]                o_state_ram_off_chip_data,
  input  logic [(STATE_DATA_WIDTH<<PE_NUM_WIDTH)-1:0] i_pe_rd_data
);

  localparam int GAW = PE_NUM_WIDTH + STATE_ADDR_WIDTH;
  localparam int CW  = GAW + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  xfer_state_e           state;
  logic [GAW-1:0]        addr_q;
  logic [CW-1:0]         rem_q;
  logic                  en_q;
  logic                  we_q;
  logic [GAW-1:0]        port_addr_q;
  logic [STATE_DATA_WIDTH-1:0] port_data_q;
  logic                  rd_vld_q;
  logic [PE_NUM_WIDTH-1:0] rd_pe_q;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [STATE_DATA_WIDTH-1:0] rd_word;

  logic                  rd_issued;
  logic [1:0]            inflight;
  logic [FCW:0]          credit_sum;
  logic                  credit_ok;
  logic                  s_accept;

  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);
  assign o_s_ready = (state == ST_LOAD) && (rem_q != '0);
  assign s_accept  = i_s_valid & o_s_ready;

  assign o_state_ram_off_chip_en   = en_q;
  assign o_state_ram_off_chip_we   = we_q;
  assign o_state_ram_off_chip_addr = port_addr_q;
  assign o_state_ram_off_chip_data = port_data_q;

  // A read is in flight from the cycle it sits on the port until its data is
  // pushed one cycle later, so the in-flight count falls out of two flops.
  assign rd_issued  = en_q & ~we_q;
  assign inflight   = {1'b0, rd_issued} + {1'b0, rd_vld_q};
  // Pops in the current cycle are ignored: conservative, still 1 word/cycle.
  assign credit_sum = {1'b0, fifo_count} + {{(FCW-1){1'b0}}, inflight};
  assign credit_ok  = credit_sum < (FCW+1)'(FIFO_DEPTH);

  assign rd_word  = i_pe_rd_data[rd_pe_q*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
  assign fifo_pop = o_m_valid & i_m_ready;
  assign o_m_valid = ~fifo_empty;

  xfer_fifo #(
    .WIDTH (STATE_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_vld_q),
    .wr_data (rd_word),
    .pop     (fifo_pop),
    .rd_data (o_m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      port_addr_q <= '0;
      port_data_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_pe_q     <= '0;
    end else begin
      // The PE field travels with the read so the return mux matches it.
      rd_vld_q <= rd_issued;
      rd_pe_q  <= port_addr_q[GAW-1 -: PE_NUM_WIDTH];
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr_q <= i_base_addr;
            rem_q  <= i_count;
            if (i_count == '0) begin
              state <= ST_DONE;
            end else if (!i_dir) begin
              state <= ST_LOAD;
            end else begin
              // First read goes out straight from the command so it hits the
              // port in the first UNLOAD cycle; FIFO is empty here.
              state       <= ST_UNLOAD;
              en_q        <= 1'b1;
              port_addr_q <= i_base_addr;
              addr_q      <= i_base_addr + GAW'(1);
              rem_q       <= i_count - CW'(1);
            end
          end
        end
        ST_LOAD: begin
          if (s_accept) begin
            en_q        <= 1'b1;
            we_q        <= 1'b1;
            port_addr_q <= addr_q;
            port_data_q <= i_s_data;
            addr_q      <= addr_q + GAW'(1);
            rem_q       <= rem_q - CW'(1);
            if (rem_q == CW'(1)) state <= ST_DONE;
          end
        end
        ST_UNLOAD: begin
          if (rem_q == '0) begin
            state <= ST_FLUSH;
          end else if (credit_ok) begin
            en_q        <= 1'b1;
            port_addr_q <= addr_q;
            addr_q      <= addr_q + GAW'(1);
            rem_q       <= rem_q - CW'(1);
            if (rem_q == CW'(1)) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (inflight == 2'd0 &&
              (fifo_empty || (fifo_count == FCW'(1) && fifo_pop)))
            state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_xfer_ctrl.sv
module tb_state_xfer_ctrl;

  localparam int GAW   = 18;
  localparam int CW    = 19;
  localparam int SDW   = 64;
  localparam int NPE   = 4;
  localparam int DEPTH = 4;
  localparam int HIST  = 4096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_dir = 1'b0;
  logic [GAW-1:0]   i_base_addr = '0;
  logic [CW-1:0]    i_count = '0;
  logic             o_busy, o_done;
  logic             i_s_valid = 1'b0;
  logic             o_s_ready;
  logic [SDW-1:0]   i_s_data = '0;
  logic             o_m_valid;
  logic             i_m_ready = 1'b0;
  logic [SDW-1:0]   o_m_data;
  logic             o_en, o_we;
  logic [GAW-1:0]   o_addr;
  logic [SDW-1:0]   o_data;
  logic [SDW*NPE-1:0] i_pe_rd_data = '0;

  always #5 clk = ~clk;

  state_xfer_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_start                   (i_start),
    .i_dir                     (i_dir),
    .i_base_addr               (i_base_addr),
    .i_count                   (i_count),
    .o_busy                    (o_busy),
    .o_done                    (o_done),
    .i_s_valid                 (i_s_valid),
    .o_s_ready                 (o_s_ready),
    .i_s_data                  (i_s_data),
    .o_m_valid                 (o_m_valid),
    .i_m_ready                 (i_m_ready),
    .o_m_data                  (o_m_data),
    .o_state_ram_off_chip_en   (o_en),
    .o_state_ram_off_chip_we   (o_we),
    .o_state_ram_off_chip_addr (o_addr),
    .o_state_ram_off_chip_data (o_data),
    .i_pe_rd_data              (i_pe_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Contents of the PE memories: PE2 holds its local address, other PEs hold
  // tagged values so a wrong PE select shows up as a data error.
  function automatic logic [SDW-1:0] pe_word(input int k, input logic [15:0] a);
    return {32'(k ^ 2), 16'h0, a};
  endfunction

  // Memory model: one-cycle read latency, every PE answers its own word.
  always @(posedge clk) begin
    if (o_en && !o_we)
      for (int k = 0; k < NPE; k++)
        i_pe_rd_data[k*SDW +: SDW] <= pe_word(k, o_addr[15:0]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  typedef struct packed {
    logic [GAW-1:0] addr;
    logic [SDW-1:0] data;
  } wr_t;

  wr_t            exp_wr[$];
  logic [SDW-1:0] exp_rd[$];
  int             rd_left = 0;
  logic [GAW-1:0] rd_next = '0;
  int             outstanding = 0;
  int             done_due = -1;
  bit             load_done_on_last = 0;
  bit             prev_stall = 0;
  logic [SDW-1:0] prev_mdata = '0;
  logic [SDW-1:0] ld_data [8];

  logic           h_en [HIST];
  logic           h_we [HIST];
  logic           h_done [HIST];
  logic           h_busy [HIST];
  logic           h_mvalid [HIST];
  logic [GAW-1:0] h_addr [HIST];
  logic [SDW-1:0] h_data [HIST];

  always @(negedge clk) begin
    wr_t w;
    if (cyc < HIST) begin
      h_en[cyc] = o_en;   h_we[cyc] = o_we;     h_done[cyc] = o_done;
      h_busy[cyc] = o_busy; h_mvalid[cyc] = o_m_valid;
      h_addr[cyc] = o_addr; h_data[cyc] = o_data;
    end
    if (rst) begin
      prev_stall = 0;
      outstanding = 0;
    end else begin
      if (o_en && o_we) begin
        if (exp_wr.size() == 0) chk("spurious_write", 1'b1, 1'b0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", o_addr, w.addr);
          chk("wr_data", o_data, w.data);
          if (exp_wr.size() == 0 && load_done_on_last) begin
            done_due = cyc;
            load_done_on_last = 0;
          end
        end
      end
      if (o_en && !o_we) begin
        if (rd_left == 0) chk("spurious_read", 1'b1, 1'b0);
        else begin
          chk("rd_addr", o_addr, rd_next);
          rd_next = rd_next + 1'b1;
          rd_left--;
          outstanding++;
        end
      end
      if (outstanding > 0) chk("fifo_bound", outstanding <= DEPTH, 1'b1);
      if (prev_stall) begin
        chk("m_hold_valid", o_m_valid, 1'b1);
        chk("m_hold_data", o_m_data, prev_mdata);
      end
      if (o_m_valid && i_m_ready) begin
        if (exp_rd.size() == 0) chk("spurious_beat", 1'b1, 1'b0);
        else begin
          chk("m_data", o_m_data, exp_rd.pop_front());
          outstanding--;
          if (exp_rd.size() == 0) done_due = cyc + 1;
        end
      end
      prev_stall = o_m_valid && !i_m_ready;
      prev_mdata = o_m_data;
      if (o_done || cyc == done_due) chk("done_timing", o_done, cyc == done_due);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_load(input logic [GAW-1:0] base, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = base + GAW'(i);
      w.data = ld_data[i];
      exp_wr.push_back(w);
    end
    load_done_on_last = 1;
  endtask

  task automatic expect_unload(input logic [GAW-1:0] base, input int n);
    logic [GAW-1:0] g;
    for (int i = 0; i < n; i++) begin
      g = base + GAW'(i);
      exp_rd.push_back(pe_word(int'(g[17:16]), g[15:0]));
    end
    rd_left = n;
    rd_next = base;
  endtask

  task automatic start_cmd(input bit dir, input logic [GAW-1:0] base,
                           input logic [CW-1:0] cnt, output int t0);
    t0 = cyc;
    i_start = 1'b1; i_dir = dir; i_base_addr = base; i_count = cnt;
    tick();
    i_start = 1'b0;
  endtask

  task automatic drive_load(input int nbeats, input bit poke);
    int  idx = 0;
    int  guard = 0;
    bit  acc;
    i_s_valid = (nbeats > 0);
    i_s_data  = ld_data[0];
    if (poke) begin
      i_start = 1'b1; i_dir = 1'b1; i_base_addr = 18'h30000; i_count = 19'd5;
    end
    while (idx < nbeats && guard < 100) begin
      @(negedge clk);
      acc = i_s_valid && o_s_ready;
      tick();
      i_start = 1'b0;
      guard++;
      if (acc) begin
        idx++;
        if (idx < nbeats) i_s_data = ld_data[idx];
        else i_s_valid = 1'b0;
      end
    end
    i_s_valid = 1'b0;
    if (idx < nbeats) chk("load_stream_timeout", 64'(idx), 64'(nbeats));
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      if (o_done) seen = 1;
      n++;
    end
    if (!seen) chk(name, 1'b0, 1'b1);
    tick();
  endtask

  task automatic run_unload(input int t0, input bit stall, input int limit, input string name);
    int n = 0;
    int ph;
    bit seen = 0;
    while (!seen && n < limit) begin
      ph = (cyc - t0) % 4;
      i_m_ready = stall ? (ph == 0 || ph == 3) : 1'b1;
      @(negedge clk);
      if (o_done) seen = 1;
      tick();
      n++;
    end
    i_m_ready = 1'b0;
    if (!seen) chk(name, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   o_busy, 0);
    chk({tag, "_done"},   o_done, 0);
    chk({tag, "_sready"}, o_s_ready, 0);
    chk({tag, "_mvalid"}, o_m_valid, 0);
    chk({tag, "_mdata"},  o_m_data, 0);
    chk({tag, "_en"},     o_en, 0);
    chk({tag, "_we"},     o_we, 0);
    chk({tag, "_addr"},   o_addr, 0);
    chk({tag, "_data"},   o_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    // Load across PE0 -> PE1 boundary.
    ld_data[0] = 64'hA; ld_data[1] = 64'hB; ld_data[2] = 64'hC; ld_data[3] = 64'hD;
    expect_load(18'h0FFFE, 4);
    start_cmd(1'b0, 18'h0FFFE, 19'd4, t0);
    drive_load(4, 1'b0);
    wait_done(20, "load_boundary_done_timeout");
    tick();
    chk("lb_first_addr", h_addr[t0+2], 18'h0FFFE);
    chk("lb_third_addr", h_addr[t0+4], 18'h10000);
    chk("lb_third_data", h_data[t0+4], 64'hC);
    chk("lb_last_en",    h_en[t0+5], 1'b1);
    chk("lb_last_addr",  h_addr[t0+5], 18'h10001);
    chk("lb_done",       h_done[t0+5], 1'b1);
    chk("lb_idle_after", h_busy[t0+6], 1'b0);

    // Unload 6 words from PE2 with 1-0-0-1 backpressure.
    expect_unload(18'h20000, 6);
    start_cmd(1'b1, 18'h20000, 19'd6, t0);
    run_unload(t0, 1'b1, 80, "unload_stall_done_timeout");
    tick();
    chk("us_first_rd_en",   h_en[t0+1], 1'b1);
    chk("us_first_rd_we",   h_we[t0+1], 1'b0);
    chk("us_first_rd_addr", h_addr[t0+1], 18'h20000);
    chk("us_mvalid_early",  h_mvalid[t0+2], 1'b0);
    chk("us_mvalid_first",  h_mvalid[t0+3], 1'b1);
    chk("us_all_beats",     64'(exp_rd.size()), 0);
    chk("us_all_reads",     64'(rd_left), 0);

    // Unload across PE1 -> PE2 at full rate.
    expect_unload(18'h1FFFE, 3);
    start_cmd(1'b1, 18'h1FFFE, 19'd3, t0);
    run_unload(t0, 1'b0, 40, "unload_fast_done_timeout");
    tick();
    chk("uf_done", h_done[t0+6], 1'b1);
    chk("uf_all_beats", 64'(exp_rd.size()), 0);

    // Zero-count command.
    start_cmd(1'b0, 18'h00123, 19'd0, t0);
    done_due = t0 + 1;
    wait_done(5, "zero_count_done_timeout");
    repeat (2) tick();
    chk("zc_done", h_done[t0+1], 1'b1);
    chk("zc_busy", h_busy[t0+1], 1'b1);
    for (int c = 0; c < 3; c++) chk("zc_no_port", h_en[t0+c], 1'b0);

    // Reset after 3 of 8 load beats.
    for (int i = 0; i < 8; i++) ld_data[i] = 64'h100 + 64'(i);
    expect_load(18'h01000, 8);
    start_cmd(1'b0, 18'h01000, 19'd8, t0);
    drive_load(3, 1'b0);
    repeat (2) tick();
    chk("rm_partial_writes", 64'(exp_wr.size()), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_wr.delete();
    load_done_on_last = 0;
    done_due = -1;
    @(negedge clk);
    check_all_zero("midreset");
    tick();
    ld_data[0] = 64'hE; ld_data[1] = 64'hF;
    expect_load(18'h02000, 2);
    start_cmd(1'b0, 18'h02000, 19'd2, t0);
    drive_load(2, 1'b0);
    wait_done(10, "post_reset_done_timeout");
    repeat (3) tick();
    chk("pr_addr0", h_addr[t0+2], 18'h02000);
    chk("pr_addr1", h_addr[t0+3], 18'h02001);
    chk("pr_queue_empty", 64'(exp_wr.size()), 0);

    // Global address wrap.
    ld_data[0] = 64'h11; ld_data[1] = 64'h22;
    expect_load(18'h3FFFF, 2);
    start_cmd(1'b0, 18'h3FFFF, 19'd2, t0);
    drive_load(2, 1'b0);
    wait_done(10, "wrap_done_timeout");
    tick();
    chk("wr_addr_hi", h_addr[t0+2], 18'h3FFFF);
    chk("wr_addr_lo", h_addr[t0+3], 18'h00000);
    chk("wr_data_lo", h_data[t0+3], 64'h22);

    // i_start while busy is ignored.
    ld_data[0] = 64'h1; ld_data[1] = 64'h2; ld_data[2] = 64'h3;
    expect_load(18'h00100, 3);
    start_cmd(1'b0, 18'h00100, 19'd3, t0);
    drive_load(3, 1'b1);
    wait_done(10, "busy_start_done_timeout");
    repeat (4) tick();
    chk("bs_done",      h_done[t0+4], 1'b1);
    chk("bs_last_addr", h_addr[t0+4], 18'h00102);
    chk("bs_idle",      h_busy[t0+6], 1'b0);
    chk("bs_no_unload", h_en[t0+6], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
